// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the multicycle MIPS control unit.
// MC_CTRL_EXT_OPS_EN adds the addi/j opcodes and their states.
package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CTRL_EXT_OPS_EN
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
`ifdef MC_CTRL_EXT_OPS_EN
   localparam logic [1:0] PC_JUMP   = 2'b10;
`endif

   typedef enum logic [3:0] {
      RSTW,
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC,
      ALUWB,
      BRANCH
`ifdef MC_CTRL_EXT_OPS_EN
      ,
      ADDIEX,
      ADDIWB,
      JUMP
`endif
   } state_t;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to the ALU control code
// and flags unsupported functs.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] aluControl,
   output logic       valid
);

   always_comb begin
      aluControl = ALU_ADD;
      valid      = 1'b1;
      case (funct)
         FUNCT_ADD: aluControl = ALU_ADD;
         FUNCT_SUB: aluControl = ALU_SUB;
         FUNCT_AND: aluControl = ALU_AND;
         FUNCT_OR:  aluControl = ALU_OR;
         FUNCT_SLT: aluControl = ALU_SLT;
         FUNCT_SLL: aluControl = ALU_SLL;
         default:   valid      = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (Moore, with IRWrite/PCEn gated by MemReady/Zero).
// Define MC_CTRL_EXT_OPS_EN to support addi and j.
module mips_multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       PCEn,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   state_t     state;
   state_t     nextState;
   logic       setIllegal;
   logic [2:0] decControl;
   logic       decValid;

   alu_decoder uAluDecoder (
      .funct      (Funct),
      .aluControl (decControl),
      .valid      (decValid)
   );

   // State register; reset parks the FSM in RSTW from any state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RSTW;
      end else begin
         state <= nextState;
      end
   end

   // Illegal is sticky: only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Illegal <= 1'b0;
      end else if (setIllegal) begin
         Illegal <= 1'b1;
      end
   end

   // Next-state and output decode from the current state.
   always_comb begin
      nextState  = state;
      setIllegal = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      PCEn       = 1'b0;
      ALUSrcB    = SRCB_B;
      PCSrc      = PC_ALU;
      ALUControl = ALU_ADD;
      case (state)
         RSTW: nextState = FETCH;
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCEn    = MemReady;
            if (MemReady) nextState = DECODE;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            case (Op)
               OP_RTYPE:     nextState = EXEC;
               OP_LW, OP_SW: nextState = MEMADR;
               OP_BEQ:       nextState = BRANCH;
`ifdef MC_CTRL_EXT_OPS_EN
               OP_ADDI:      nextState = ADDIEX;
               OP_J:         nextState = JUMP;
`endif
               default: begin
                  setIllegal = 1'b1;
                  nextState  = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            nextState = (Op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (MemReady) nextState = MEMWB;
         end
         MEMWB: begin
            RegWrite  = 1'b1;
            MemtoReg  = 1'b1;
            nextState = FETCH;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) nextState = FETCH;
         end
         EXEC: begin
            ALUSrcA    = 1'b1;
            ALUControl = decControl;
            if (decValid) begin
               nextState = ALUWB;
            end else begin
               setIllegal = 1'b1;
               nextState  = FETCH;
            end
         end
         ALUWB: begin
            RegWrite  = 1'b1;
            RegDst    = 1'b1;
            nextState = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = PC_ALUOUT;
            PCEn       = Zero;
            nextState  = FETCH;
         end
`ifdef MC_CTRL_EXT_OPS_EN
         ADDIEX: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            nextState = ADDIWB;
         end
         ADDIWB: begin
            RegWrite  = 1'b1;
            nextState = FETCH;
         end
         JUMP: begin
            PCSrc     = PC_JUMP;
            PCEn      = 1'b1;
            nextState = FETCH;
         end
`endif
         default: nextState = RSTW;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control; each step drives
// inputs at the falling edge and checks the full output vector 1 ns later.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSrc;
   logic [2:0] ALUControl;
   logic       Illegal;

   int checks = 0;
   int errors = 0;

   // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,PCEn, ALUSrcB, PCSrc, ALUControl}
   localparam logic [15:0] E_DEF    = 16'b000000000_00_00_010;
   localparam logic [15:0] E_FETCH1 = 16'b010100001_01_00_010;
   localparam logic [15:0] E_FETCH0 = 16'b010000000_01_00_010;
   localparam logic [15:0] E_DECODE = 16'b000000000_11_00_010;
   localparam logic [15:0] E_MEMADR = 16'b000000010_10_00_010;
   localparam logic [15:0] E_MEMRD  = 16'b110000000_00_00_010;
   localparam logic [15:0] E_MEMWB  = 16'b000001100_00_00_010;
   localparam logic [15:0] E_MEMWR  = 16'b101000000_00_00_010;
   localparam logic [15:0] E_EXSUB  = 16'b000000010_00_00_110;
   localparam logic [15:0] E_EXSLL  = 16'b000000010_00_00_100;
   localparam logic [15:0] E_ALUWB  = 16'b000010100_00_00_010;
   localparam logic [15:0] E_BRZ1   = 16'b000000011_00_01_110;
   localparam logic [15:0] E_BRZ0   = 16'b000000010_00_01_110;
`ifdef MC_CTRL_EXT_OPS_EN
   localparam logic [15:0] E_JUMP   = 16'b000000001_00_10_010;
`endif

   localparam logic [5:0] OPR = 6'b000000;
   localparam logic [5:0] OLW = 6'b100011;
   localparam logic [5:0] OSW = 6'b101011;
   localparam logic [5:0] OBQ = 6'b000100;
   localparam logic [5:0] OJ  = 6'b000010;
   localparam logic [5:0] OBD = 6'b111111;
   localparam logic [5:0] FSUB = 6'b100010;
   localparam logic [5:0] FSLL = 6'b000000;
   localparam logic [5:0] FBAD = 6'b111111;

   mips_multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Op         (Op),
      .Funct      (Funct),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .PCEn       (PCEn),
      .ALUSrcB    (ALUSrcB),
      .PCSrc      (PCSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                input logic zero, input logic ready);
      Op       = op;
      Funct    = funct;
      Zero     = zero;
      MemReady = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] expCtl, input logic expIll);
      logic [16:0] obs;
      logic [16:0] exp;
      #1;
      obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn,
             ALUSrcB, PCSrc, ALUControl, Illegal};
      exp = {expCtl, expIll};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input logic ready, input string tag, input logic [15:0] expCtl,
                       input logic expIll);
      applyStimulus(op, funct, zero, ready);
      checkOutput(tag, expCtl, expIll);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(OPR, FSUB, 1'b0, 1'b0);
      @(negedge clk);
      step(OPR, FSUB, 0, 1, "reset_hold", E_DEF, 0);
      rst_n = 1'b1;
      step(OPR, FSUB, 0, 1, "rstw_release", E_DEF, 0);

      // R-type sub, 4 cycles
      step(OPR, FSUB, 0, 1, "sub_fetch",  E_FETCH1, 0);
      step(OPR, FSUB, 0, 1, "sub_decode", E_DECODE, 0);
      step(OPR, FSUB, 0, 1, "sub_exec",   E_EXSUB,  0);
      step(OPR, FSUB, 0, 1, "sub_aluwb",  E_ALUWB,  0);

      // lw with three wait cycles in MEMRD, writeback at cycle 8
      step(OLW, FSUB, 0, 1, "lw_fetch",   E_FETCH1, 0);
      step(OLW, FSUB, 0, 1, "lw_decode",  E_DECODE, 0);
      step(OLW, FSUB, 0, 1, "lw_memadr",  E_MEMADR, 0);
      step(OLW, FSUB, 0, 0, "lw_memrd_w1", E_MEMRD, 0);
      step(OLW, FSUB, 0, 0, "lw_memrd_w2", E_MEMRD, 0);
      step(OLW, FSUB, 0, 0, "lw_memrd_w3", E_MEMRD, 0);
      step(OLW, FSUB, 0, 1, "lw_memrd_ok", E_MEMRD, 0);
      step(OLW, FSUB, 0, 1, "lw_memwb",   E_MEMWB,  0);

      // sw with a fetch wait
      step(OSW, FSUB, 0, 0, "sw_fetch_wait", E_FETCH0, 0);
      step(OSW, FSUB, 0, 1, "sw_fetch",   E_FETCH1, 0);
      step(OSW, FSUB, 0, 1, "sw_decode",  E_DECODE, 0);
      step(OSW, FSUB, 0, 1, "sw_memadr",  E_MEMADR, 0);
      step(OSW, FSUB, 0, 1, "sw_memwr",   E_MEMWR,  0);

      // sw interrupted by reset while waiting in MEMWR
      step(OSW, FSUB, 0, 1, "sw2_fetch",  E_FETCH1, 0);
      step(OSW, FSUB, 0, 1, "sw2_decode", E_DECODE, 0);
      step(OSW, FSUB, 0, 1, "sw2_memadr", E_MEMADR, 0);
      applyStimulus(OSW, FSUB, 0, 0);
      checkOutput("sw2_memwr_wait", E_MEMWR, 0);
      rst_n = 1'b0;
      checkOutput("sw2_memwr_reset", E_DEF, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(OBQ, FSUB, 1, 1, "rstw_release2", E_DEF, 0);

      // beq taken and not taken
      step(OBQ, FSUB, 1, 1, "beq1_fetch",  E_FETCH1, 0);
      step(OBQ, FSUB, 1, 1, "beq1_decode", E_DECODE, 0);
      step(OBQ, FSUB, 1, 1, "beq1_branch", E_BRZ1,   0);
      step(OBQ, FSUB, 0, 1, "beq0_fetch",  E_FETCH1, 0);
      step(OBQ, FSUB, 0, 1, "beq0_decode", E_DECODE, 0);
      step(OBQ, FSUB, 0, 1, "beq0_branch", E_BRZ0,   0);

      // sll
      step(OPR, FSLL, 0, 1, "sll_fetch",  E_FETCH1, 0);
      step(OPR, FSLL, 0, 1, "sll_decode", E_DECODE, 0);
      step(OPR, FSLL, 0, 1, "sll_exec",   E_EXSLL,  0);
      step(OPR, FSLL, 0, 1, "sll_aluwb",  E_ALUWB,  0);

      // j
      step(OJ, FSUB, 0, 1, "j_fetch",  E_FETCH1, 0);
      step(OJ, FSUB, 0, 1, "j_decode", E_DECODE, 0);
`ifdef MC_CTRL_EXT_OPS_EN
      step(OJ, FSUB, 0, 1, "j_jump",   E_JUMP,   0);
      step(OJ, FSUB, 0, 1, "j_next_fetch", E_FETCH1, 0);
`else
      step(OJ, FSUB, 0, 1, "j_illegal_fetch", E_FETCH1, 1);
`endif

      rst_n = 1'b0;
      step(OBD, FSUB, 0, 1, "reset_clears", E_DEF, 0);
      rst_n = 1'b1;
      step(OBD, FSUB, 0, 1, "rstw_release3", E_DEF, 0);

      // illegal opcode stays flagged across a following valid sub
      step(OBD, FSUB, 0, 1, "bad_fetch",  E_FETCH1, 0);
      step(OBD, FSUB, 0, 1, "bad_decode", E_DECODE, 0);
      step(OPR, FSUB, 0, 1, "post_fetch",  E_FETCH1, 1);
      step(OPR, FSUB, 0, 1, "post_decode", E_DECODE, 1);
      step(OPR, FSUB, 0, 1, "post_exec",   E_EXSUB,  1);
      step(OPR, FSUB, 0, 1, "post_aluwb",  E_ALUWB,  1);
      step(OPR, FSUB, 0, 1, "post_fetch2", E_FETCH1, 1);

      rst_n = 1'b0;
      step(OPR, FBAD, 0, 1, "reset_clears2", E_DEF, 0);
      rst_n = 1'b1;
      step(OPR, FBAD, 0, 1, "rstw_release4", E_DEF, 0);

      // bad funct skips writeback and flags Illegal
      step(OPR, FBAD, 0, 1, "badf_fetch",  E_FETCH1, 0);
      step(OPR, FBAD, 0, 1, "badf_decode", E_DECODE, 0);
      applyStimulus(OPR, FBAD, 0, 1);
      @(negedge clk);
      step(OPR, FSUB, 0, 1, "badf_next_fetch", E_FETCH1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle MIPS control unit. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives the datapath muxes, the register-file and memory enables, and the 3-bit ALU control code consumed by the ALU. It sits between the instruction register and the datapath, consumes the ALU `Zero` flag for `beq`, and handshakes with instruction/data memory through `MemReady`.

## Interface
- Parameters: none; all encodings are fixed MIPS32 constants.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Op` in 6: instruction[31:26].
- `Funct` in 6: instruction[5:0].
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completed the current access this cycle.
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`, `PCEn` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 = B reg, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSrc` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ALUControl` out 3: AND 000, OR 001, ADD 010, SLL 100, SUB 110, SLT 111.
- `Illegal` out 1: sticky flag, unsupported instruction decoded.

## Operation
- Moore FSM. All outputs decode from the current state, except `IRWrite` and `PCEn`, which are gated combinationally by `MemReady` or `Zero` as listed below.
- Output defaults when a state does not set them: all 1-bit outputs 0, `ALUSrcB` 00, `PCSrc` 00, `ALUControl` 010.
- RSTW: all outputs at default. Goes to FETCH unconditionally.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, ADD, `PCSrc`=00, `IRWrite`=`PCEn`=`MemReady`. Holds until `MemReady`, then goes to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, ADD. Next state by `Op`:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - anything else: set `Illegal`, go to FETCH
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `IorD`=1, `MemRead`=1. Holds until `MemReady`, then goes to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Goes to FETCH.
- MEMWR: `IorD`=1, `MemWrite`=1. Holds until `MemReady`, then goes to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUControl` decoded from `Funct`:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL
  - any other `Funct`: set `Illegal`, go to FETCH with no writeback
  - valid `Funct`: go to ALUWB
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Goes to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCSrc`=01, `PCEn`=`Zero`. Goes to FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Goes to ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Goes to FETCH.
- JUMP: `PCSrc`=10, `PCEn`=1. Goes to FETCH.
- `Illegal` is a register, set one cycle after the offending DECODE/EXEC and cleared only by reset. The PC is already incremented, so execution continues with the next instruction.
- `MemReady` is ignored in every state except FETCH, MEMRD and MEMWR.

## Timing
- Cycles per instruction with `MemReady` held at 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- Each cycle of `MemReady`=0 in a wait state adds exactly one cycle. `MemRead`/`MemWrite` stay asserted and stable during the wait.
- Reset: `rst_n` low forces RSTW asynchronously from any state, including mid-wait. All outputs take defaults immediately (`MemWrite`=0, `PCEn`=0, `RegWrite`=0) and `Illegal`=0.
- After `rst_n` deasserts: first rising edge enters FETCH, so the first fetch is requested at cycle 1.

## Configuration
- `MC_CTRL_EXT_OPS_EN` defined: addi and j are supported; ADDIEX, ADDIWB and JUMP exist.
- Undefined: opcodes 001000 and 000010 are illegal. DECODE sets `Illegal` and returns to FETCH; those states are not synthesized.

## Structure
- Shared package `mips_pkg`: ALU control codes, opcode and funct constants, state enumeration, `ALUSrcB`/`PCSrc` encodings.
- One sub-module, `alu_decoder`: combinational `Funct` → {`ALUControl`, valid}, instantiated for EXEC.

## Test plan
- Reset mid-MEMWR (`MemReady`=0, `MemWrite`=1), assert `rst_n`=0 → `MemWrite` drops in the same cycle; FETCH one cycle after release.
- `Op`=000000, `Funct`=100010, `MemReady`=1 → `ALUControl`=110 in EXEC, `RegWrite`=`RegDst`=1 in cycle 4, back to FETCH.
- lw with `MemReady` low for 3 cycles in MEMRD → `MemRead`=1, `IorD`=1 held; MEMWB at cycle 8; total 8 cycles.
- beq with `Zero`=1 → `PCEn`=1, `PCSrc`=01 in BRANCH. Repeat with `Zero`=0 → `PCEn`=0.
- `Op`=111111 → `Illegal`=1 from the cycle after DECODE, stays 1 across following valid instructions until reset.
- `Op`=000000, `Funct`=000000 → `ALUControl`=100 in EXEC. j with macro undefined → `Illegal`=1 and `PCEn` never asserted with `PCSrc`=10.
